switch_port_requester: RTL

- Input-port request agent for the 4-port switch; drives the requester side of the per-output round-robin req/grant interface.
- Takes packets from the input-port buffer, decodes the destination from the header flit, and raises req[dest] toward the output arbiters.
- Holds req[dest] until it receives grant[dest], then streams the whole packet through a one-deep registered output stage to the switch fabric.
- Flags starvation, protocol errors and spurious grants.

---
 rtl/switch_port_requester.sv | 120 ++++++++++++
 1 files changed

// File: rtl/switch_port_requester.sv
// switch_port_requester: input-port agent that requests an output arbiter, waits for its grant,
// then streams the packet through a one-deep registered stage to the fabric.
module switch_port_requester #(
    parameter int DW         = 32,
    parameter int DEST_LSB   = 0,
    parameter int STARVE_CYC = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_sop,
    input  logic          in_eop,
    output logic          in_ready,
    output logic [3:0]    req,
    input  logic [3:0]    grant,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_sop,
    output logic          out_eop,
    output logic [1:0]    out_dest,
    input  logic          out_ready,
    output logic          starve,
    output logic          err_proto,
    output logic          err_grant
);
    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
    localparam logic [15:0] STARVE_MAX = 16'(STARVE_CYC);
    state_t        state_q, state_d;
    logic [1:0]    dest_q, dest_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [3:0]    dest_oh;
    logic          accept, load;
    logic          out_valid_q, out_valid_d, out_sop_q, out_eop_q;
    logic [DW-1:0] out_data_q;
    logic [1:0]    out_dest_q;
    logic          starve_q, starve_d, err_proto_q, err_proto_d, err_grant_q, err_grant_d;

    assign dest_oh = 4'b0001 << dest_q;

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        cnt_d       = '0;
        starve_d    = starve_q;
        err_proto_d = err_proto_q;
        err_grant_d = err_grant_q | ((state_q == REQ) ? |(grant & ~dest_oh) : |grant);
        req         = '0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_sop) begin
                    dest_d  = in_data[DEST_LSB +: 2];
                    state_d = REQ;
                end else if (in_valid) begin
                    accept      = 1'b1;
                    err_proto_d = 1'b1;
                end
            end
            REQ: begin
                // drop the request in the grant cycle so the arbiter never re-grants
                req      = grant[dest_q] ? 4'b0000 : dest_oh;
                cnt_d    = (cnt_q == STARVE_MAX) ? cnt_q : cnt_q + 16'd1;
                starve_d = starve_q | (cnt_d == STARVE_MAX);
                if (grant[dest_q])
                    state_d = XFER;
            end
            XFER: begin
                accept = in_valid && (!out_valid_q || out_ready);
                if (accept && in_eop)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign load        = accept && (state_q == XFER);
    assign out_valid_d = load || (out_valid_q && !out_ready);
    // nothing may be accepted while the agent is held in reset
    assign in_ready    = accept && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_dest_q  <= '0;
            starve_q    <= 1'b0;
            err_proto_q <= 1'b0;
            err_grant_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            starve_q    <= starve_d;
            err_proto_q <= err_proto_d;
            err_grant_q <= err_grant_d;
            if (load) begin
                out_data_q <= in_data;
                out_sop_q  <= in_sop;
                out_eop_q  <= in_eop;
                out_dest_q <= dest_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_dest  = out_dest_q;
    assign starve    = starve_q;
    assign err_proto = err_proto_q;
    assign err_grant = err_grant_q;
endmodule
